// File: rtl/reduceron_pkg.sv
// Shared types for the Reduceron run sequencer: run states and the IO write word.
package reduceron_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 13;
  localparam int TAG_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } io_req_t;

endpackage

// File: rtl/reduceron_io_fifo.sv
// First-word fall-through FIFO for core IO writes; head is read straight from storage.
module reduceron_io_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/reduceron_run_ctrl.sv
// Reduceron run sequencer: releases the core on start, stalls it on IO back-pressure,
// captures result and cycle count on finish/timeout, then drains the IO FIFO.
module reduceron_run_ctrl
  import reduceron_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SLACK   = 2,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              core_rst_n,
  output logic              core_en,
  input  logic              iowrite,
  input  logic [ADDR_W-1:0] ioaddr,
  input  logic [DATA_W-1:0] iowd,
  input  logic              finish,
  input  logic [15:0]       r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [12:0]       result,
  output logic [TAG_W-1:0]  result_tag,
  output logic [CNT_W-1:0]  cycles,
  output logic              timed_out,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] EN_LIMIT = (PTR_W+1)'(DEPTH - 1 - SLACK);

  run_state_t        state_r, next_state_s;
  logic              core_rst_n_r, core_en_r, busy_r, done_r;
  logic              timed_out_r, overflow_r;
  logic [12:0]       result_r;
  logic [TAG_W-1:0]  result_tag_r;
  logic [CNT_W-1:0]  cycles_r;

  io_req_t           push_word_s, head_s;
  logic [PTR_W:0]    count_s, count_next_s;
  logic              full_s, empty_s;
  logic              push_req_s, push_ok_s, pop_s;
  logic              start_run_s, timeout_hit_s;

  assign push_word_s.addr = ioaddr;
  assign push_word_s.data = iowd;
  assign push_req_s       = (state_r == RUN) && iowrite;
  assign pop_s            = out_valid && out_ready;
  assign push_ok_s        = push_req_s && (!full_s || pop_s);
  assign start_run_s      = start && ((state_r == IDLE) || (state_r == DONE));
  assign timeout_hit_s    = (TIMEOUT != 0) && (state_r == RUN) && core_en_r &&
                            (cycles_r == CNT_W'(TIMEOUT - 1));

  reduceron_io_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(io_req_t))
  ) u_io_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign out_valid = !empty_s;
  assign out_addr  = head_s.addr;
  assign out_data  = head_s.data;

  // Occupancy after this edge, so the registered stall tracks the live FIFO count.
  always_comb begin
    count_next_s = count_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_s + 1'b1;
      2'b01:   count_next_s = count_s - 1'b1;
      default: count_next_s = count_s;
    endcase
  end

  // Run sequencing; finish takes priority over the timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE, DONE: if (start) next_state_s = RUN;   else next_state_s = state_r;
      RUN:        if (finish || timeout_hit_s) next_state_s = DRAIN; else next_state_s = RUN;
      DRAIN:      if (empty_s) next_state_s = DONE; else next_state_s = DRAIN;
      default:    next_state_s = IDLE;
    endcase
  end

  // State, registered control outputs and run capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      core_rst_n_r <= 1'b0;
      core_en_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      result_r     <= '0;
      result_tag_r <= '0;
      cycles_r     <= '0;
      timed_out_r  <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      core_rst_n_r <= (next_state_s == RUN) || (next_state_s == DRAIN);
      busy_r       <= (next_state_s == RUN) || (next_state_s == DRAIN);
      done_r       <= (next_state_s == DONE);
      core_en_r    <= (next_state_s == RUN) && (count_next_s <= EN_LIMIT);
      if (start_run_s) begin
        cycles_r     <= '0;
        result_r     <= '0;
        result_tag_r <= '0;
        timed_out_r  <= 1'b0;
        overflow_r   <= 1'b0;
      end else begin
        if ((state_r == RUN) && core_en_r && (cycles_r != '1)) cycles_r <= cycles_r + 1'b1;
        if ((state_r == RUN) && finish) begin
          result_r     <= r[15:3];
          result_tag_r <= r[2:0];
        end else if (timeout_hit_s) begin
          timed_out_r <= 1'b1;
        end
        if (push_req_s && full_s && !pop_s) overflow_r <= 1'b1;
      end
    end
  end

  assign core_rst_n = core_rst_n_r;
  assign core_en    = core_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign result     = result_r;
  assign result_tag = result_tag_r;
  assign cycles     = cycles_r;
  assign timed_out  = timed_out_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_reduceron_run_ctrl.sv
// Directed bench for reduceron_run_ctrl: table of basic runs plus hand-written corner sequences.
module tb_reduceron_run_ctrl;

  localparam int DEPTH   = 16;
  localparam int SLACK   = 2;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 100;

  logic              clock = 1'b0;
  logic              reset_n, start, iowrite, finish, out_ready;
  logic [12:0]       ioaddr, iowd;
  logic [15:0]       r;
  logic              core_rst_n, core_en, out_valid, busy, done, timed_out, overflow;
  logic [12:0]       out_addr, out_data, result;
  logic [2:0]        result_tag;
  logic [CNT_W-1:0]  cycles;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  reduceron_run_ctrl #(
    .DEPTH(DEPTH), .SLACK(SLACK), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .core_rst_n(core_rst_n),
    .core_en(core_en), .iowrite(iowrite), .ioaddr(ioaddr), .iowd(iowd),
    .finish(finish), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done),
    .result(result), .result_tag(result_tag), .cycles(cycles),
    .timed_out(timed_out), .overflow(overflow)
  );

  typedef struct {
    logic [15:0] rv;
    int          n;
    logic [12:0] res;
    logic [2:0]  tag;
  } run_vec_t;

  run_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_pulse(input logic [15:0] rv);
    finish = 1'b1;
    r      = rv;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] ea;
    logic        seen;

    vecs[0] = '{16'h0015, 40, 13'h0002, 3'd5};
    vecs[1] = '{16'hFFFF, 1,  13'h1FFF, 3'd7};
    vecs[2] = '{16'h0008, 7,  13'h0001, 3'd0};
    vecs[3] = '{16'hABCD, 20, 13'h1579, 3'd5};

    reset_n = 1'b0; start = 1'b0; iowrite = 1'b0; ioaddr = '0; iowd = '0;
    finish = 1'b0; r = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst core_rst_n", core_rst_n, 0);
    check("rst core_en",    core_en,    0);
    check("rst out_valid",  out_valid,  0);
    check("rst busy",       busy,       0);
    check("rst done",       done,       0);
    check("rst result",     result,     0);
    check("rst tag",        result_tag, 0);
    check("rst cycles",     cycles,     0);
    check("rst timed_out",  timed_out,  0);
    check("rst overflow",   overflow,   0);
    reset_n = 1'b1;
    tick();
    check("idle core_rst_n", core_rst_n, 0);

    // basic runs from the table
    for (int v = 0; v < 4; v++) begin
      pulse_start();
      check("run busy",       busy,       1);
      check("run core_en",    core_en,    1);
      check("run core_rst_n", core_rst_n, 1);
      check("run cycles0",    cycles,     0);
      repeat (vecs[v].n - 1) tick();
      finish_pulse(vecs[v].rv);
      check("fin result", result,     vecs[v].res);
      check("fin tag",    result_tag, vecs[v].tag);
      check("fin cycles", cycles,     vecs[v].n);
      check("drain done", done,       0);
      tick();
      check("done flag",       done,       1);
      check("done core_rst_n", core_rst_n, 0);
      check("done busy",       busy,       0);
    end

    // IO ordering with a ready consumer
    out_ready = 1'b1;
    pulse_start();
    iowrite = 1'b1; ioaddr = 13'd5; iowd = 13'd100; tick();
    check("ord v0", out_valid, 1); check("ord a0", out_addr, 5); check("ord d0", out_data, 100);
    ioaddr = 13'd6; iowd = 13'd200; tick();
    check("ord v1", out_valid, 1); check("ord a1", out_addr, 6); check("ord d1", out_data, 200);
    ioaddr = 13'd7; iowd = 13'd300; tick();
    check("ord v2", out_valid, 1); check("ord a2", out_addr, 7); check("ord d2", out_data, 300);
    iowrite = 1'b0; tick();
    check("ord empty", out_valid, 0);
    check("ord overflow", overflow, 0);
    finish_pulse(16'h0000);
    tick();
    check("ord done", done, 1);

    // back-pressure: stall at 14 entries, one in-flight write still accepted
    out_ready = 1'b0;
    pulse_start();
    for (int j = 1; j <= 15; j++) begin
      iowrite = 1'b1; ioaddr = 13'(j); iowd = 13'(j * 3);
      tick();
      check("bp core_en", core_en, (j <= DEPTH - 1 - SLACK));
    end
    iowrite = 1'b0;
    check("bp overflow", overflow, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check("bp valid", out_valid, 1);
      check("bp addr",  out_addr,  k + 1);
      check("bp data",  out_data,  (k + 1) * 3);
      tick();
      check("bp core_en drain", core_en, ((14 - k) <= DEPTH - 1 - SLACK));
    end
    check("bp empty", out_valid, 0);
    finish_pulse(16'h0000);
    tick();
    check("bp done", done, 1);

    // overflow, then push+pop while full
    out_ready = 1'b0;
    pulse_start();
    for (int j = 1; j <= 17; j++) begin
      iowrite = 1'b1; ioaddr = 13'(j); iowd = 13'(2 * j + 1);
      tick();
      check("ovf flag", overflow, (j > DEPTH));
    end
    ioaddr = 13'd99; iowd = 13'd199; out_ready = 1'b1;
    tick();
    iowrite = 1'b0; out_ready = 1'b0;
    finish_pulse(16'hFFFF);
    check("ovf drain busy",    busy,       1);
    check("ovf drain core_en", core_en,    0);
    check("ovf drain rst_n",   core_rst_n, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ea = (k < 15) ? 13'(k + 2) : 13'd99;
      check("ovf valid", out_valid, 1);
      check("ovf addr",  out_addr,  ea);
      check("ovf data",  out_data,  13'(2 * ea + 1));
      check("ovf not done", done, 0);
      tick();
    end
    check("ovf empty", out_valid, 0);
    tick();
    check("ovf done", done, 1);
    check("ovf sticky", overflow, 1);

    // timeout run; start from DONE clears sticky flags
    pulse_start();
    check("clr overflow", overflow,   0);
    check("clr cycles",   cycles,     0);
    check("clr result",   result,     0);
    check("clr tag",      result_tag, 0);
    repeat (99) tick();
    check("to before", timed_out, 0);
    check("to cyc99",  cycles,    99);
    tick();
    check("to flag",    timed_out, 1);
    check("to cycles",  cycles,    100);
    check("to busy",    busy,      1);
    check("to core_en", core_en,   0);
    tick();
    check("to done", done, 1);

    // finish coincides with timeout: finish wins
    pulse_start();
    check("clr timed_out", timed_out, 0);
    repeat (99) tick();
    finish_pulse(16'h1234);
    check("tie timed_out", timed_out, 0);
    check("tie result",    result,    13'h0246);
    check("tie tag",       result_tag, 4);
    check("tie cycles",    cycles,    100);
    tick();
    check("tie done", done, 1);

    // reset while draining with queued entries; start in DRAIN ignored
    out_ready = 1'b0;
    pulse_start();
    for (int j = 0; j < 5; j++) begin
      iowrite = 1'b1; ioaddr = 13'(40 + j); iowd = 13'(j); tick();
    end
    iowrite = 1'b0;
    finish_pulse(16'h0000);
    check("md busy", busy, 1);
    pulse_start();
    check("md start ignored busy", busy,      1);
    check("md start ignored done", done,      0);
    check("md head kept",          out_addr,  40);
    seen = out_valid;
    check("md valid", seen, 1);
    reset_n = 1'b0;
    tick();
    check("md rst valid", out_valid,  0);
    check("md rst busy",  busy,       0);
    check("md rst rst_n", core_rst_n, 0);
    reset_n = 1'b1;
    tick();
    check("md idle valid", out_valid, 0);
    check("md idle done",  done,      0);
    pulse_start();
    check("md restart busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
